xalu_ctrl: RTL
==============

Name: xalu_ctrl

Overview:
- Sequencer for the multiply/divide unit (XALU) beside the E-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from E and owns the HI/LO registers.
- Holds the unit busy for a fixed, parameterised latency.
- Drives stall_md to the hazard/pause logic so that a D-stage MD instruction waits until the unit is free.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  E-stage MD instruction valid this cycle
- md_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
- a  in  32  forwarded rs operand (MF_RS_E output)
- b  in  32  forwarded rt operand (MF_RT_E output)
- md_D  in  1  D-stage instruction is an MD-class op (mult/div/mfhi/mflo/mthi/mtlo)
- busy  out  1  unit computing
- done  out  1  one-cycle pulse after HI/LO commit
- stall_md  out  1  stall request to the pause unit
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset=0, asynchronous):
  - hi=0, lo=0, busy=0, done=0.
  - counter=0, state=IDLE, latched operands=0.
  - Any operation in flight is aborted and its result discarded.
- States:
  - IDLE -> BUSY on a start edge with md_op 0-3. BUSY -> IDLE when the counter reaches 1.
  - No other states.
- Start of a mult/div in IDLE (clock edge):
  - Latch a, b and md_op.
  - Load the counter with MULT_CYCLES or DIV_CYCLES; busy<=1.
  - busy is therefore high for exactly N cycles after the start edge.
- In BUSY, each edge decrements the counter. At the edge where counter==1:
  - hi/lo <= result from the latched operands.
  - busy<=0, done<=1 for one cycle.
- hi/lo hold their old values throughout BUSY.
- MTHI/MTLO in IDLE: hi (or lo) <= a on the start edge; busy stays 0; no done pulse.
- md_op 6/7 with start: no effect.
- start while BUSY (any op): ignored. The pause unit must prevent this; the bench checks that no state changes.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
    - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU: unsigned lo = quotient, hi = remainder.
  - Divide by zero: full DIV_CYCLES busy period, hi/lo unchanged, done still pulses.
- stall_md = md_D & (busy | (start & md_op<=3)). Combinational, no registered latency.
  - A D-stage MD op is released in the cycle after the last busy cycle, so mfhi/mflo in D then sees the new hi/lo.
- done and busy are never high in the same cycle.
- Same-edge start and completion is impossible, since start is ignored while busy.

Decomposition:
- Shared package xalu_pkg holds:
  - md_op codes: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5.
  - State encoding: IDLE=0, BUSY=1.
- Sub-module xalu_core holds the 64-bit multiply and the 32-bit divide/remainder.
  - Inputs: latched op and operands. Output: {hi_next, lo_next}.
  - Divide-by-zero hold and the INT_MIN/-1 rule are implemented here.
- xalu_ctrl holds the FSM, counter, operand latches, HI/LO registers and the stall logic.

Test Plan:
1. Reset low mid-DIV (3rd busy cycle), then release -> busy=0, hi=0, lo=0 immediately; no done pulse.
2. MULT a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses 1 cycle; hi/lo unchanged during busy.
3. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
4. DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then DIVU a=5, b=0 -> hi/lo unchanged, busy 10 cycles, done pulses.
5. MULT issued with md_D=1 held every cycle -> stall_md=1 on the start cycle and all 5 busy cycles, 0 on the following cycle. With md_D=0 throughout, stall_md stays 0.
6. MTHI a=0x12345678 in IDLE -> hi=0x12345678 next edge, busy stays 0. A start with MTLO during a DIV busy period -> lo unchanged, counter unaffected.

Source files
------------

// File: rtl/xalu_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM state encoding and a small op-classification helper.
package xalu_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } xalu_state_t;

    // True for the ops that occupy the unit for a multi-cycle busy period.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

endpackage

// File: rtl/xalu_core.sv
// Combinational datapath: 64-bit multiply and 32-bit divide/remainder.
// Division is done on magnitudes so INT_MIN / -1 wraps to INT_MIN naturally.
import xalu_pkg::*;

module xalu_core (
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_res
);

    logic        w_signed;
    logic [63:0] w_a64;
    logic [63:0] w_b64;
    logic [63:0] w_prod;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic        w_div_zero;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_signed   = (i_op == MD_MULT) || (i_op == MD_DIV);

    assign w_a64      = {{32{w_signed & i_a[31]}}, i_a};
    assign w_b64      = {{32{w_signed & i_b[31]}}, i_b};
    assign w_prod     = w_a64 * w_b64;

    assign w_a_neg    = w_signed & i_a[31];
    assign w_b_neg    = w_signed & i_b[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - i_a) : i_a;
    assign w_b_mag    = w_b_neg ? (32'd0 - i_b) : i_b;
    // Divisor forced to 1 on zero so the divider never sees an undefined operand.
    assign w_div_zero = (i_b == 32'd0);
    assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
    assign w_q_mag    = w_a_mag / w_b_safe;
    assign w_r_mag    = w_a_mag % w_b_safe;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // Select the {hi, lo} result; divide by zero leaves HI/LO as they were.
    always_comb begin
        o_res = {i_hi, i_lo};
        case (i_op)
            MD_MULT, MD_MULTU: o_res = w_prod;
            MD_DIV, MD_DIVU: begin
                if (w_div_zero) begin
                    o_res = {i_hi, i_lo};
                end else begin
                    o_res = {w_rem, w_quot};
                end
            end
            default: o_res = {i_hi, i_lo};
        endcase
    end

endmodule

// File: rtl/xalu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, counts a fixed busy latency per op
// and raises stall_md so a D-stage MD instruction waits for the unit.
import xalu_pkg::*;

module xalu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_D,
    output logic        busy,
    output logic        done,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    xalu_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic             r_busy;
    logic             r_done;

    xalu_state_t      w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       w_op_next;
    logic [31:0]      w_a_next;
    logic [31:0]      w_b_next;
    logic [31:0]      w_hi_next;
    logic [31:0]      w_lo_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic [63:0]      w_res;

    xalu_core u_core (
        .i_op  (r_op),
        .i_a   (r_a),
        .i_b   (r_b),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .o_res (w_res)
    );

    // State, counter, operand latches and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_op    <= w_op_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic; any start seen while BUSY is deliberately ignored.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_op_next    = r_op;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            w_op_next    = md_op;
                            w_a_next     = a;
                            w_b_next     = b;
                            w_cnt_next   = CNT_MULT;
                            w_busy_next  = 1'b1;
                            w_state_next = ST_BUSY;
                        end
                        MD_DIV, MD_DIVU: begin
                            w_op_next    = md_op;
                            w_a_next     = a;
                            w_b_next     = b;
                            w_cnt_next   = CNT_DIV;
                            w_busy_next  = 1'b1;
                            w_state_next = ST_BUSY;
                        end
                        MD_MTHI: w_hi_next = a;
                        MD_MTLO: w_lo_next = a;
                        default: w_state_next = ST_IDLE;
                    endcase
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (r_cnt == CNT_ONE) begin
                    w_hi_next    = w_res[63:32];
                    w_lo_next    = w_res[31:0];
                    w_cnt_next   = '0;
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next   = r_cnt - CNT_ONE;
                    w_busy_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    // Combinational so the stall asserts in the same cycle the op is issued.
    assign stall_md = md_D & (r_busy | (start & md_is_arith(md_op)));

endmodule
